// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 sprite drawer: display geometry, RAM
// address width and the drawer FSM state encoding.
package chip8_pkg;
    localparam int DISP_W = 64;
    localparam int DISP_H = 32;
    localparam int AW     = 12;

    typedef enum logic [2:0] {IDLE, FETCH, DRAW, CLEAR, DONE} draw_state_t;
endpackage

// File: rtl/chip8_sprite_drawer_if.sv
// Request/RAM/status bundle between the CPU execute stage, sprite RAM and the
// drawer. master = CPU + RAM side, slave = the drawer.
interface chip8_sprite_drawer_if #(
    parameter int AW     = chip8_pkg::AW,
    parameter int DISP_W = chip8_pkg::DISP_W,
    parameter int DISP_H = chip8_pkg::DISP_H
);
    logic                           draw_start;
    logic                           clear_start;
    logic [7:0]                     x_pos;
    logic [7:0]                     y_pos;
    logic [3:0]                     height;
    logic [AW-1:0]                  sprite_addr;
    logic [AW-1:0]                  mem_addr;
    logic                           mem_rd;
    logic [7:0]                     mem_rdata;
    logic [DISP_W-1:0][DISP_H-1:0]  display;
    logic                           busy;
    logic                           done;
    logic                           collision;

    modport master (
        output draw_start, clear_start, x_pos, y_pos, height, sprite_addr, mem_rdata,
        input  mem_addr, mem_rd, display, busy, done, collision
    );
    modport slave (
        input  draw_start, clear_start, x_pos, y_pos, height, sprite_addr, mem_rdata,
        output mem_addr, mem_rd, display, busy, done, collision
    );
endinterface

// File: rtl/chip8_sprite_row_merge.sv
// XORs one sprite byte into 8 existing pixels; bit 7 of the sprite maps to
// pixel 0. Masked-off pixels pass through and never flag a collision.
module chip8_sprite_row_merge (
    input  logic [7:0] old_px,
    input  logic [7:0] sprite,
    input  logic [7:0] mask,
    output logic [7:0] new_px,
    output logic       coll
);
    logic [7:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < 8; i++) hit[i] = sprite[7-i] & mask[i];
        new_px = old_px ^ hit;
        coll   = |(old_px & hit);
    end
endmodule

// File: rtl/chip8_sprite_drawer.sv
// CHIP-8 framebuffer writer: DXYN sprite XOR-draw and CLS, one column per cycle.
// Define CHIP8_SPRITE_WRAP_EN to wrap off-edge pixels instead of clipping them.
module chip8_sprite_drawer #(
    parameter int DISP_W = chip8_pkg::DISP_W,
    parameter int DISP_H = chip8_pkg::DISP_H,
    parameter int AW     = chip8_pkg::AW
) (
    input logic                  Clk,
    input logic                  Reset,
    chip8_sprite_drawer_if.slave bus
);
    import chip8_pkg::*;

    localparam int XW = $clog2(DISP_W);
    localparam int YW = $clog2(DISP_H);

    draw_state_t                   state_q, state_d;
    logic [XW-1:0]                 x0_q, x0_d, clr_x_q, clr_x_d;
    logic [YW-1:0]                 y0_q, y0_d;
    logic [3:0]                    n_q, n_d, r_q, r_d;
    logic [AW-1:0]                 base_q, base_d, mem_addr_q, mem_addr_d;
    logic                          mem_rd_q, mem_rd_d, busy_q, busy_d;
    logic                          done_q, done_d, coll_q, coll_d;
    logic [DISP_W-1:0][DISP_H-1:0] disp_q, disp_d;

    logic [7:0][XW-1:0] px_x;
    logic [YW-1:0]      px_y;
    logic [7:0]         old_px, new_px, in_bounds;
    logic               row_coll;
    logic [XW:0]        xs;
    logic [YW:0]        ys;

    // Target coordinates of the 8 pixels of the current row, always wrapped;
    // in_bounds decides whether a wrapped position may actually be written.
    always_comb begin
        xs        = '0;
        px_x      = '0;
        old_px    = '0;
        in_bounds = '0;
        ys        = {1'b0, y0_q} + (YW+1)'(r_q);
        px_y      = YW'((ys >= (YW+1)'(DISP_H)) ? ys - (YW+1)'(DISP_H) : ys);
        for (int i = 0; i < 8; i++) begin
            xs      = {1'b0, x0_q} + (XW+1)'(i);
            px_x[i] = XW'((xs >= (XW+1)'(DISP_W)) ? xs - (XW+1)'(DISP_W) : xs);
`ifdef CHIP8_SPRITE_WRAP_EN
            in_bounds[i] = 1'b1;
`else
            in_bounds[i] = (xs < (XW+1)'(DISP_W)) && (ys < (YW+1)'(DISP_H));
`endif
            old_px[i] = disp_q[px_x[i]][px_y];
        end
    end

    chip8_sprite_row_merge u_merge (
        .old_px (old_px),
        .sprite (bus.mem_rdata),
        .mask   (in_bounds),
        .new_px (new_px),
        .coll   (row_coll)
    );

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        n_d        = n_q;
        r_d        = r_q;
        base_d     = base_q;
        mem_addr_d = mem_addr_q;
        clr_x_d    = clr_x_q;
        coll_d     = coll_q;
        disp_d     = disp_q;
        unique case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    state_d = CLEAR;
                    clr_x_d = '0;
                    coll_d  = 1'b0;
                end else if (bus.draw_start) begin
                    x0_d       = XW'(32'(bus.x_pos) % DISP_W);
                    y0_d       = YW'(32'(bus.y_pos) % DISP_H);
                    n_d        = bus.height;
                    base_d     = bus.sprite_addr;
                    r_d        = '0;
                    coll_d     = 1'b0;
                    mem_addr_d = bus.sprite_addr;
                    state_d    = (bus.height == 4'd0) ? DONE : FETCH;
                end
            end
            FETCH: state_d = DRAW;
            DRAW: begin
                for (int i = 0; i < 8; i++)
                    if (in_bounds[i]) disp_d[px_x[i]][px_y] = new_px[i];
                if (row_coll) coll_d = 1'b1;
                if (r_q == n_q - 4'd1) begin
                    state_d = DONE;
                end else begin
                    r_d        = r_q + 4'd1;
                    mem_addr_d = base_q + AW'(r_d);
                    state_d    = FETCH;
                end
            end
            CLEAR: begin
                disp_d[clr_x_q] = '0;
                coll_d          = 1'b0;
                if (clr_x_q == XW'(DISP_W - 1)) state_d = DONE;
                else                            clr_x_d = clr_x_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_rd_d = (state_d == FETCH);
        done_d   = (state_d == DONE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            n_q        <= '0;
            r_q        <= '0;
            base_q     <= '0;
            mem_addr_q <= '0;
            clr_x_q    <= '0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            coll_q     <= 1'b0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            n_q        <= n_d;
            r_q        <= r_d;
            base_q     <= base_d;
            mem_addr_q <= mem_addr_d;
            clr_x_q    <= clr_x_d;
            mem_rd_q   <= mem_rd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            coll_q     <= coll_d;
            disp_q     <= disp_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.collision = coll_q;
    assign bus.display   = disp_q;
endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Directed bench for chip8_sprite_drawer: glyph draw/undraw, collision, edge
// clip/wrap, coordinate wrap, CLS priority, busy lockout and mid-draw reset.
module tb_chip8_sprite_drawer;
    typedef logic [63:0][31:0] disp_t;

    logic  Clk, Reset;
    logic  [7:0] ram [0:4095];
    disp_t exp_disp;
    int    vectors, miscompares, d;

    chip8_sprite_drawer_if bus ();

    chip8_sprite_drawer dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous RAM: data valid the cycle after mem_rd
    always @(posedge Clk) if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int first_diff(input disp_t a, input disp_t b);
        for (int x = 0; x < 64; x++) if (a[x] !== b[x]) return x;
        return 0;
    endfunction

    task automatic start_draw(input logic [7:0] x, input logic [7:0] y,
                              input logic [3:0] h, input logic [11:0] a);
        @(negedge Clk);
        bus.x_pos = x; bus.y_pos = y; bus.height = h; bus.sprite_addr = a;
        bus.draw_start = 1'b1;
        @(negedge Clk);
        bus.draw_start = 1'b0;
    endtask

    // k0 = rising edges already seen since (and including) the accept edge
    task automatic run_to_done(input int k0, input int exp, input string nm);
        int k;
        k = k0;
        while (bus.done !== 1'b1 && k < 400) begin @(negedge Clk); k++; end
        vectors++;
        if (k != exp) begin
            miscompares++;
            $display("FAIL %s_latency: done after %0d edges, want %0d", nm, k, exp);
        end
        @(negedge Clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: done=%b busy=%b, want 0 0", nm, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        vectors++;
        if ({bus.busy, bus.done, bus.collision, bus.mem_rd} !== 4'b0000 || bus.mem_addr !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_status: busy=%b done=%b coll=%b rd=%b addr=%h, want all 0",
                     bus.busy, bus.done, bus.collision, bus.mem_rd, bus.mem_addr);
        end
        vectors++;
        if (bus.display !== '0) begin
            miscompares++; d = first_diff(bus.display, '0);
            $display("FAIL reset_display: col %0d got %h want 0", d, bus.display[d]);
        end
    endtask

    task automatic test_glyph(input string nm, input logic exp_coll);
        start_draw(8'd0, 8'd0, 4'd5, 12'h050);
        vectors++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 12'h050 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_fetch0: rd=%b addr=%h busy=%b, want 1 050 1", nm, bus.mem_rd, bus.mem_addr, bus.busy);
        end
        @(negedge Clk);
        vectors++;
        if (bus.mem_rd !== 1'b0) begin
            miscompares++; $display("FAIL %s_draw_rd: rd=%b, want 0", nm, bus.mem_rd);
        end
        @(negedge Clk);
        vectors++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 12'h051) begin
            miscompares++;
            $display("FAIL %s_fetch1: rd=%b addr=%h, want 1 051", nm, bus.mem_rd, bus.mem_addr);
        end
        run_to_done(3, 11, nm);
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < 8; i++)
                if (ram[12'h050 + r][7-i]) exp_disp[i][r] = ~exp_disp[i][r];
        vectors++;
        if (bus.display !== exp_disp) begin
            miscompares++; d = first_diff(bus.display, exp_disp);
            $display("FAIL %s_display: col %0d got %h want %h", nm, d, bus.display[d], exp_disp[d]);
        end
        vectors++;
        if (bus.collision !== exp_coll) begin
            miscompares++; $display("FAIL %s_coll: got %b want %b", nm, bus.collision, exp_coll);
        end
    endtask

    task automatic test_coord_wrap();
        start_draw(8'd70, 8'd40, 4'd0, 12'h300);
        run_to_done(1, 1, "h0");
        vectors++;
        if (bus.display !== exp_disp || bus.collision !== 1'b0) begin
            miscompares++; d = first_diff(bus.display, exp_disp);
            $display("FAIL h0_unchanged: coll=%b col %0d got %h want %h", bus.collision, d, bus.display[d], exp_disp[d]);
        end
        start_draw(8'd70, 8'd40, 4'd1, 12'h300);
        run_to_done(1, 3, "xy_mod");
        exp_disp[6][8] = 1'b1;
        start_draw(8'd10, 8'd10, 4'd2, 12'hFFF);
        run_to_done(1, 5, "addr_wrap");
        exp_disp[10][10] = 1'b1;
        exp_disp[11][11] = 1'b1;
        vectors++;
        if (bus.display !== exp_disp) begin
            miscompares++; d = first_diff(bus.display, exp_disp);
            $display("FAIL coord_display: col %0d got %h want %h", d, bus.display[d], exp_disp[d]);
        end
    endtask

    task automatic test_edge();
        start_draw(8'd62, 8'd31, 4'd2, 12'h100);
        run_to_done(1, 5, "edge");
`ifdef CHIP8_SPRITE_WRAP_EN
        for (int i = 0; i < 8; i++) begin
            exp_disp[(62+i)%64][31] = 1'b1;
            exp_disp[(62+i)%64][0]  = 1'b1;
        end
`else
        exp_disp[62][31] = 1'b1;
        exp_disp[63][31] = 1'b1;
`endif
        vectors++;
        if (bus.display !== exp_disp || bus.collision !== 1'b0) begin
            miscompares++; d = first_diff(bus.display, exp_disp);
            $display("FAIL edge_display: coll=%b col %0d got %h want %h", bus.collision, d, bus.display[d], exp_disp[d]);
        end
    endtask

    task automatic test_busy_ignore();
        start_draw(8'd20, 8'd20, 4'd2, 12'h100);
        @(negedge Clk);
        bus.clear_start = 1'b1; bus.draw_start = 1'b1;
        @(negedge Clk);
        bus.clear_start = 1'b0; bus.draw_start = 1'b0;
        run_to_done(3, 5, "busy_ign");
        for (int i = 20; i < 28; i++) begin exp_disp[i][20] = 1'b1; exp_disp[i][21] = 1'b1; end
        vectors++;
        if (bus.display !== exp_disp || bus.collision !== 1'b0) begin
            miscompares++; d = first_diff(bus.display, exp_disp);
            $display("FAIL busy_ign_display: coll=%b col %0d got %h want %h", bus.collision, d, bus.display[d], exp_disp[d]);
        end
    endtask

    task automatic test_clear();
        @(negedge Clk);
        bus.clear_start = 1'b1;
        @(negedge Clk);
        bus.clear_start = 1'b0;
        run_to_done(1, 65, "cls");
        for (int cx = 0; cx < 8; cx++) begin
            start_draw(8'(cx*8), 8'd0,  4'd15, 12'h200); run_to_done(1, 31, "fill");
            start_draw(8'(cx*8), 8'd15, 4'd15, 12'h200); run_to_done(1, 31, "fill");
            start_draw(8'(cx*8), 8'd30, 4'd2,  12'h200); run_to_done(1, 5,  "fill");
        end
        exp_disp = '1;
        vectors++;
        if (bus.display !== exp_disp || bus.collision !== 1'b0) begin
            miscompares++; d = first_diff(bus.display, exp_disp);
            $display("FAIL fill_display: coll=%b col %0d got %h want %h", bus.collision, d, bus.display[d], exp_disp[d]);
        end
        start_draw(8'd0, 8'd0, 4'd1, 12'h200);
        run_to_done(1, 3, "overdraw");
        vectors++;
        if (bus.collision !== 1'b1 || bus.display[3] !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL overdraw: coll=%b col3=%h, want 1 fffffffe", bus.collision, bus.display[3]);
        end
        @(negedge Clk);
        bus.clear_start = 1'b1; bus.draw_start = 1'b1;
        bus.x_pos = 8'd40; bus.y_pos = 8'd4; bus.height = 4'd3; bus.sprite_addr = 12'h200;
        @(negedge Clk);
        bus.clear_start = 1'b0; bus.draw_start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.mem_rd !== 1'b0 || bus.collision !== 1'b0) begin
            miscompares++;
            $display("FAIL cls_prio: busy=%b rd=%b coll=%b, want 1 0 0", bus.busy, bus.mem_rd, bus.collision);
        end
        repeat (9) @(negedge Clk);
        vectors++;
        if (bus.display[8] !== 32'h0 || bus.display[9] !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL cls_progress: col8=%h col9=%h, want 00000000 ffffffff", bus.display[8], bus.display[9]);
        end
        run_to_done(10, 65, "cls_prio");
        exp_disp = '0;
        vectors++;
        if (bus.display !== exp_disp || bus.collision !== 1'b0) begin
            miscompares++; d = first_diff(bus.display, exp_disp);
            $display("FAIL cls_result: coll=%b col %0d got %h want %h", bus.collision, d, bus.display[d], exp_disp[d]);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        start_draw(8'd0, 8'd0, 4'd1, 12'h200);
        run_to_done(1, 3, "pre_rst");
        start_draw(8'd0, 8'd0, 4'd3, 12'h200);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        vectors++;
        if (bus.display !== '0 || {bus.busy, bus.done, bus.collision, bus.mem_rd} !== 4'b0000 || bus.mem_addr !== 12'h000) begin
            miscompares++;
            $display("FAIL rst_mid: busy=%b done=%b coll=%b rd=%b addr=%h col0=%h, want all 0",
                     bus.busy, bus.done, bus.collision, bus.mem_rd, bus.mem_addr, bus.display[0]);
        end
        Reset = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin @(negedge Clk); if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1; end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++; $display("FAIL rst_no_done: got activity=%b want 0", saw_done);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; d = 0;
        bus.draw_start = 1'b0; bus.clear_start = 1'b0;
        bus.x_pos = '0; bus.y_pos = '0; bus.height = '0; bus.sprite_addr = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h050] = 8'hF0; ram[12'h051] = 8'h90; ram[12'h052] = 8'h90;
        ram[12'h053] = 8'h90; ram[12'h054] = 8'hF0;
        ram[12'h100] = 8'hFF; ram[12'h101] = 8'hFF;
        ram[12'h300] = 8'h80;
        ram[12'hFFF] = 8'h80; ram[12'h000] = 8'h40;
        for (int i = 0; i < 15; i++) ram[12'h200 + i] = 8'hFF;
        exp_disp = '0;

        test_reset();
        test_glyph("glyph", 1'b0);
        test_glyph("undraw", 1'b1);
        test_coord_wrap();
        test_edge();
        test_busy_ignore();
        test_clear();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
